// File: rtl/vga_pkg.sv
// Shared types for the scaled VGA overlay layer: register offsets, bpp encoding,
// control word layout and the full per-layer register set.
package vga_pkg;

    localparam logic [2:0] REG_BASE   = 3'd0;
    localparam logic [2:0] REG_X1     = 3'd1;
    localparam logic [2:0] REG_Y1     = 3'd2;
    localparam logic [2:0] REG_X2     = 3'd3;
    localparam logic [2:0] REG_Y2     = 3'd4;
    localparam logic [2:0] REG_STRIDE = 3'd5;
    localparam logic [2:0] REG_CTRL   = 3'd6;
    localparam logic [2:0] REG_KEY    = 3'd7;

    typedef enum logic [1:0] {
        BPP_8    = 2'd0,
        BPP_16   = 2'd1,
        BPP_32   = 2'd2,
        BPP_RSVD = 2'd3
    } bpp_t;

    typedef struct packed {
        logic       key_en;
        bpp_t       bpp;
        logic [1:0] yscale;
        logic [1:0] xscale;
        logic       enable;
    } layer_ctrl_t;

    // Fields are stored at bus width; the top slices them to ADDR_W / COORD_W.
    typedef struct packed {
        logic [31:0] base;
        logic [15:0] x1;
        logic [15:0] y1;
        logic [15:0] x2;
        logic [15:0] y2;
        logic [15:0] stride;
        layer_ctrl_t ctrl;
        logic [31:0] key;
    } layer_regs_t;

    function automatic layer_regs_t layer_reset_regs(input logic        is_layer0,
                                                     input logic [31:0] fb_base,
                                                     input logic [15:0] scr_w,
                                                     input logic [15:0] scr_h);
        layer_regs_t r;
        r = '0;
        if (is_layer0) begin
            r.base        = fb_base;
            r.x2          = scr_w;
            r.y2          = scr_h;
            r.stride      = scr_w;
            r.ctrl.enable = 1'b1;
        end else begin
            // x1 >= x2 and y1 >= y2: an empty rectangle until software programs one
            r.x1 = scr_w;
            r.y1 = scr_h;
        end
        return r;
    endfunction

    // Reserved bpp encoding behaves as 32bpp everywhere downstream.
    function automatic logic [1:0] bpp_shift(input bpp_t b);
        return (b == BPP_RSVD) ? 2'd2 : b;
    endfunction

endpackage

// File: rtl/vga_layer_regs.sv
// Register decode with PENDING (written any time) and ACTIVE (copied at frame start) sets,
// so geometry never changes mid-frame.
module vga_layer_regs
    import vga_pkg::*;
#(
    parameter logic [2:0]  LAYER_ID = 3'b000,
    parameter logic [31:0] FB_BASE  = 32'h03f80000,
    parameter int          SCREEN_W = 640,
    parameter int          SCREEN_H = 480
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        hwregs_write,
    input  logic [7:0]  hwregs_addr,
    input  logic [31:0] hwregs_wdata,
    input  logic        new_frame,
    output layer_regs_t pending_regs,
    output layer_regs_t active_regs
);

    localparam logic GEOM_LOCKED = (LAYER_ID == 3'd0);

    layer_regs_t pending_d, pending_q;
    layer_regs_t active_d, active_q;
    logic        sel;

    assign sel = hwregs_write && (hwregs_addr[7:5] == LAYER_ID);

    always_comb begin
        pending_d = pending_q;
        // The copy uses the pre-write value, so a coincident write lands one frame later.
        active_d  = new_frame ? pending_q : active_q;
        if (sel) begin
            case (hwregs_addr[4:2])
                REG_BASE:   pending_d.base = hwregs_wdata;
                REG_X1:     if (!GEOM_LOCKED) pending_d.x1 = hwregs_wdata[15:0];
                REG_Y1:     if (!GEOM_LOCKED) pending_d.y1 = hwregs_wdata[15:0];
                REG_X2:     if (!GEOM_LOCKED) pending_d.x2 = hwregs_wdata[15:0];
                REG_Y2:     if (!GEOM_LOCKED) pending_d.y2 = hwregs_wdata[15:0];
                REG_STRIDE: if (!GEOM_LOCKED) pending_d.stride = hwregs_wdata[15:0];
                REG_CTRL:   pending_d.ctrl = layer_ctrl_t'(hwregs_wdata[7:0]);
                REG_KEY:    pending_d.key = hwregs_wdata;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pending_q <= layer_reset_regs(GEOM_LOCKED, FB_BASE, 16'(SCREEN_W), 16'(SCREEN_H));
            active_q  <= layer_reset_regs(GEOM_LOCKED, FB_BASE, 16'(SCREEN_W), 16'(SCREEN_H));
        end else begin
            pending_q <= pending_d;
            active_q  <= active_d;
        end
    end

    assign pending_regs = pending_q;
    assign active_regs  = active_q;

    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^hwregs_addr[1:0];

endmodule

// File: rtl/vga_scaled_layer.sv
// Overlay layer fetch-address generator: rectangle test, x/y pixel replication and
// the SDRAM byte-address walk, all driven from the frame-latched register set.
module vga_scaled_layer
    import vga_pkg::*;
#(
    parameter logic [2:0]        LAYER_ID = 3'b000,
    parameter int                ADDR_W   = 26,
    parameter int                COORD_W  = 10,
    parameter int                SCALE_W  = 2,
    parameter logic [ADDR_W-1:0] FB_BASE  = 26'h3f80000,
    parameter int                SCREEN_W = 640,
    parameter int                SCREEN_H = 480
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               hwregs_write,
    input  logic [7:0]         hwregs_addr,
    input  logic [31:0]        hwregs_wdata,
    input  logic [COORD_W-1:0] pixel_x,
    input  logic [COORD_W-1:0] pixel_y,
    input  logic               next_pixel,
    input  logic               next_line,
    input  logic               new_frame,
    output logic [ADDR_W-1:0]  layer_address,
    output logic               layer_active,
    output logic [1:0]         layer_bpp,
    output logic [31:0]        layer_key,
    output logic               layer_key_en
);

    localparam int                CNT_W      = (1 << SCALE_W) - 1;
    localparam logic [ADDR_W-1:0] RESET_BASE = (LAYER_ID == 3'd0) ? FB_BASE : '0;

    layer_regs_t pending_regs, active_regs;

    vga_layer_regs #(
        .LAYER_ID (LAYER_ID),
        .FB_BASE  (32'(FB_BASE)),
        .SCREEN_W (SCREEN_W),
        .SCREEN_H (SCREEN_H)
    ) u_regs (
        .clock        (clock),
        .reset        (reset),
        .hwregs_write (hwregs_write),
        .hwregs_addr  (hwregs_addr),
        .hwregs_wdata (hwregs_wdata),
        .new_frame    (new_frame),
        .pending_regs (pending_regs),
        .active_regs  (active_regs)
    );

    logic [COORD_W-1:0] x1, y1, x2, y2;
    logic [ADDR_W-1:0]  stride, pix_step, frame_base;
    logic [CNT_W-1:0]   x_last, y_last;
    logic               in_x, in_y;

    assign x1         = active_regs.x1[COORD_W-1:0];
    assign y1         = active_regs.y1[COORD_W-1:0];
    assign x2         = active_regs.x2[COORD_W-1:0];
    assign y2         = active_regs.y2[COORD_W-1:0];
    assign stride     = ADDR_W'(active_regs.stride);
    assign pix_step   = ADDR_W'(1) << bpp_shift(active_regs.ctrl.bpp);
    // The frame about to start uses the set being latched, not the outgoing one.
    assign frame_base = pending_regs.base[ADDR_W-1:0];
    assign x_last     = (CNT_W'(1) << active_regs.ctrl.xscale) - CNT_W'(1);
    assign y_last     = (CNT_W'(1) << active_regs.ctrl.yscale) - CNT_W'(1);
    assign in_x       = (pixel_x >= x1) && (pixel_x < x2);
    assign in_y       = (pixel_y >= y1) && (pixel_y < y2);

    logic [ADDR_W-1:0] cur_addr_d, cur_addr_q, line_addr_d, line_addr_q;
    logic [CNT_W-1:0]  xcnt_d, xcnt_q, ycnt_d, ycnt_q;
    logic              frame_valid_d, frame_valid_q;
    logic              layer_active_d, layer_active_q;
    logic [ADDR_W-1:0] layer_address_d, layer_address_q;

    always_comb begin
        cur_addr_d    = cur_addr_q;
        line_addr_d   = line_addr_q;
        xcnt_d        = xcnt_q;
        ycnt_d        = ycnt_q;
        frame_valid_d = frame_valid_q;
        if (new_frame) begin
            cur_addr_d    = frame_base;
            line_addr_d   = frame_base;
            xcnt_d        = '0;
            ycnt_d        = '0;
            frame_valid_d = 1'b1;
        end else if (next_line) begin
            if (in_y) begin
                xcnt_d = '0;
                if (ycnt_q == y_last) begin
                    ycnt_d      = '0;
                    line_addr_d = line_addr_q + stride;
                    cur_addr_d  = line_addr_q + stride;
                end else begin
                    ycnt_d     = ycnt_q + CNT_W'(1);
                    cur_addr_d = line_addr_q;
                end
            end
        end else if (next_pixel && in_x && in_y) begin
            if (xcnt_q == x_last) begin
                xcnt_d     = '0;
                cur_addr_d = cur_addr_q + pix_step;
            end else begin
                xcnt_d = xcnt_q + CNT_W'(1);
            end
        end
        // A reset mid-frame keeps the layer dark until the next frame start.
        layer_active_d  = in_x && in_y && active_regs.ctrl.enable && frame_valid_q;
        layer_address_d = cur_addr_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cur_addr_q      <= RESET_BASE;
            line_addr_q     <= RESET_BASE;
            xcnt_q          <= '0;
            ycnt_q          <= '0;
            frame_valid_q   <= 1'b0;
            layer_active_q  <= 1'b0;
            layer_address_q <= '0;
        end else begin
            cur_addr_q      <= cur_addr_d;
            line_addr_q     <= line_addr_d;
            xcnt_q          <= xcnt_d;
            ycnt_q          <= ycnt_d;
            frame_valid_q   <= frame_valid_d;
            layer_active_q  <= layer_active_d;
            layer_address_q <= layer_address_d;
        end
    end

    assign layer_active  = layer_active_q;
    assign layer_address = layer_address_q;
    assign layer_bpp     = bpp_shift(active_regs.ctrl.bpp);
    assign layer_key     = active_regs.key;
    assign layer_key_en  = active_regs.ctrl.key_en;

    logic unused_regs;
    assign unused_regs = ^{pending_regs, active_regs};

endmodule
